// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN      - datapath / address width
//   PC_INCR   - sequential PC step (one 32-bit word)
//   PC_AHEAD  - pipeline PC offset added to branch targets
//   fetch_state_e - FETCH (request outstanding), HOLD (instr waiting for decode),
//                   DRAIN (discarding a request made stale by a redirect)
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_INCR  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_AHEAD = XLEN'(8);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_target.sv
// Branch target adder: target_c = br_base + PC_AHEAD + br_imm (mod 2^32).
// Purely combinational.
//   br_base  in  PC of the branch instruction
//   br_imm   in  sign-extended, word-scaled branch offset
//   target_c out redirect address
module fetch_target
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] br_base,
    input  logic [XLEN-1:0] br_imm,
    output logic [XLEN-1:0] target_c
);

    assign target_c = br_base + PC_AHEAD + br_imm;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word reads to instruction memory, hands the
// fetched word to decode, and handles redirects from execute.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
//   clk, reset                 clock, async active-high reset
//   imem_req/addr, ack/rdata   instruction memory request / response
//   instr_valid/instr/instr_pc instruction to decode, accepted by instr_ready
//   br_taken/br_base/br_imm    redirect request from execute
//   perf_fetched, perf_stall   (FETCH_PERF_CNT_EN only) event counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_base,
    input  logic [XLEN-1:0] br_imm
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_stall
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_next_q, pc_next_d;   // redirect target parked during DRAIN
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] target_c;
    logic            ack_c;

    // An ack only counts against a request we actually have outstanding.
    assign ack_c = imem_ack & req_q;

    fetch_target u_target (
        .br_base  (br_base),
        .br_imm   (br_imm),
        .target_c (target_c)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            pc_next_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_next_q  <= pc_next_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
        end
    end

    // Next-state logic; br_taken wins over every other event.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_next_d  = pc_next_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            FETCH: begin
                if (br_taken) begin
                    // Live request still in flight: park target until it drains.
                    if (req_q && !imem_ack) begin
                        pc_next_d = target_c;
                        state_d   = DRAIN;
                    end else begin
                        pc_d = target_c;
                    end
                end else if (ack_c) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (br_taken) begin
                    valid_d = 1'b0;
                    pc_d    = target_c;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + PC_INCR;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (br_taken && ack_c) begin
                    pc_d    = target_c;
                    state_d = FETCH;
                end else if (br_taken) begin
                    pc_next_d = target_c;
                end else if (ack_c) begin
                    pc_d    = pc_next_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        req_d = (state_d != HOLD);
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] perf_fetched_q, perf_fetched_d;
    logic [XLEN-1:0] perf_stall_q, perf_stall_d;

    // Counters: accepted instructions and memory wait cycles.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (state_q == HOLD && instr_ready && !br_taken) begin
            perf_fetched_d = perf_fetched_q + XLEN'(1);
        end
        if (state_q != HOLD && req_q && !imem_ack) begin
            perf_stall_d = perf_stall_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit (RESET_PC = 0x100). Stimulus pushes the
// expected request address of every memory ack and the expected (instr, pc)
// of every instruction that should reach decode; monitors pop and compare.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_base;
    logic [31:0] br_imm;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .br_taken    (br_taken),
        .br_base     (br_base),
        .br_imm      (br_imm)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_instr_t;

    exp_instr_t  instr_sb[$];
    logic [31:0] addr_sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_rise = 0;
    int          rise_gap = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: request address on each ack, instruction on each valid rise.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ack) begin
                if (addr_sb.size() > 0) check("req_addr", imem_addr, addr_sb.pop_front());
                else fail_now("unexpected_ack");
            end
            if (instr_valid && !prev_valid) begin
                rise_gap  = cyc - last_rise;
                last_rise = cyc;
                if (instr_sb.size() > 0) begin
                    exp_instr_t e;
                    e = instr_sb.pop_front();
                    check("instr", instr, e.data);
                    check("instr_pc", instr_pc, e.pc);
                end else begin
                    fail_now("unexpected_instr_valid");
                end
            end
        end
        prev_valid = instr_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) fail_now("req_timeout");
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        if (!instr_valid) fail_now("valid_timeout");
    endtask

    // Serve one memory read after 'waits' wait states; keep=0 means the word is to be discarded.
    task automatic mem_fetch(input logic [31:0] a, input logic [31:0] d, input int waits, input bit keep);
        exp_instr_t e;
        wait_req();
        for (int i = 0; i < waits; i++) begin
            check("wait_addr", imem_addr, a);
            tick();
        end
        addr_sb.push_back(a);
        if (keep) begin
            e.data = d;
            e.pc   = a;
            instr_sb.push_back(e);
        end
        imem_ack   = 1'b1;
        imem_rdata = d;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic accept();
        wait_valid();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic branch(input logic [31:0] base, input logic [31:0] imm);
        br_taken = 1'b1;
        br_base  = base;
        br_imm   = imm;
        tick();
        br_taken = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_base     = '0;
        br_imm      = '0;
        snap        = '0;
        repeat (3) tick();

        // Reset values
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h100);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        reset = 1'b0;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h100);

        // Zero-wait first fetch, then back-to-back sequential stream
        mem_fetch(32'h100, 32'hE3A0_1005, 0, 1);
        check("valid_after_ack", 32'(instr_valid), 32'd1);
        accept();
        check("seq_addr", imem_addr, 32'h104);
        mem_fetch(32'h104, 32'h1111_0104, 0, 1);
        accept();
        mem_fetch(32'h108, 32'h2222_0108, 0, 1);
        accept();
        check("throughput_gap", 32'(rise_gap), 32'd2);

        // HOLD is stable without ready, then redirect with negative offset
        mem_fetch(32'h10C, 32'h3333_010C, 0, 1);
        tick();
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, 32'h3333_010C);
        check("throughput_gap2", 32'(rise_gap), 32'd2);
        branch(32'h200, 32'hFFFF_FFF8);
        check("hold_br_valid", 32'(instr_valid), 32'd0);
        check("hold_br_addr", imem_addr, 32'h200);
        mem_fetch(32'h200, 32'h4444_0200, 0, 1);
        accept();

        // Redirect during a 3-wait-state fetch: old word drained, never presented
        wait_req();
        check("drain_old_addr", imem_addr, 32'h204);
        tick();
        tick();
        branch(32'h3F8, 32'h0);
        check("drain_req", 32'(imem_req), 32'd1);
        mem_fetch(32'h204, 32'hDEAD_BEEF, 0, 0);
        check("drain_new_addr", imem_addr, 32'h400);
        mem_fetch(32'h400, 32'h5555_0400, 0, 1);
        accept();

        // Redirect coincident with ack: data dropped, target requested next cycle
        wait_req();
        addr_sb.push_back(32'h404);
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0404;
        br_taken   = 1'b1;
        br_base    = 32'h500;
        br_imm     = 32'h10;
        tick();
        imem_ack   = 1'b0;
        br_taken   = 1'b0;
        check("coinc_addr", imem_addr, 32'h518);
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_valid", 32'(instr_valid), 32'd0);
        mem_fetch(32'h518, 32'h6666_0518, 0, 1);

        // PC wrap at top of address space, 2 wait states
        wait_valid();
        branch(32'hFFFF_FFF4, 32'h0);
        check("wrap_br_addr", imem_addr, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
        snap = perf_stall;
`endif
        mem_fetch(32'hFFFF_FFFC, 32'h7777_FFFC, 2, 1);
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall_delta", perf_stall - snap, 32'd2);
        snap = perf_fetched;
`endif
        accept();
        check("wrap_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched_delta", perf_fetched - snap, 32'd1);
`endif
        mem_fetch(32'h0, 32'h8888_0000, 0, 1);
        accept();

        // Reset mid-request, late ack while imem_req is low is ignored
        wait_req();
        reset = 1'b1;
        tick();
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_addr", imem_addr, 32'h100);
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0004;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        check("late_ack_req", 32'(imem_req), 32'd1);
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        mem_fetch(32'h100, 32'h9999_0100, 1, 1);
        accept();
        tick();

        check("addr_sb_empty", 32'(addr_sb.size()), 32'd0);
        check("instr_sb_empty", 32'(instr_sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
